// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner for the lock front end.
// Drives one-hot column strobes, samples synchronised row returns, debounces
// a single key press and its release, and rejects multi-key/ghost patterns.
// Emits a one-cycle Valid pulse with the linear key Code, and a Held level
// that stays high until the key is cleanly released.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SETTLE   = 3,
    parameter int DEBOUNCE = 4,
    localparam int CW      = $clog2(ROWS * COLS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [ROWS-1:0] Row,
    output logic [COLS-1:0] Col,
    output logic [CW-1:0]   Code,
    output logic            Valid,
    output logic            Held
);

    localparam int RIW  = $clog2(ROWS);
    localparam int CIW  = $clog2(COLS);
    localparam int MAXC = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
    localparam int CNTW = $clog2(MAXC + 1);

    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
    localparam logic [CNTW-1:0] DEB_LAST    = CNTW'(DEBOUNCE - 1);
    localparam logic [CNTW-1:0] CNT_MAX     = CNTW'(MAXC);
    localparam logic [CIW-1:0]  COL_LAST    = CIW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED
    } state_t;

    state_t          state;
    logic [ROWS-1:0] rs_meta;
    logic [ROWS-1:0] rs;
    logic [CNTW-1:0] cnt;
    logic [CIW-1:0]  col_idx;
    logic [ROWS-1:0] row_hot;
    logic [RIW-1:0]  row_idx;

    // One-hot column strobe for a given column index.
    function automatic logic [COLS-1:0] col_onehot(input logic [CIW-1:0] idx);
        return COLS'(1) << idx;
    endfunction

    // Index of the single set bit of a one-hot row vector.
    function automatic logic [RIW-1:0] row_index(input logic [ROWS-1:0] hot);
        logic [RIW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (hot[i]) idx = RIW'(i);
        end
        return idx;
    endfunction

    // Counters stop at their ceiling instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Two-flop synchroniser for the asynchronous row returns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs_meta <= '0;
            rs      <= '0;
        end else begin
            // NOTE: non-blocking assignments make rs take the old rs_meta, giving
            // two real flop stages; blocking here would collapse them into one.
            rs_meta <= Row;
            rs      <= rs_meta;
        end
    end

    // Scan / debounce / release FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            Col     <= '1;
            Code    <= '0;
            Valid   <= 1'b0;
            Held    <= 1'b0;
            cnt     <= '0;
            col_idx <= '0;
            row_hot <= '0;
            row_idx <= '0;
        end else begin
            // Valid is a single-cycle pulse; only the press path raises it.
            Valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    Col <= '1;
                    if (rs != '0) begin
                        state   <= S_SCAN;
                        col_idx <= '0;
                        Col     <= col_onehot('0);
                        cnt     <= '0;
                    end
                end

                S_SCAN: begin
                    if (cnt == SETTLE_LAST) begin
                        // Sample point: last cycle of this column's settle window.
                        cnt <= '0;
                        if ($onehot(rs)) begin
                            state   <= S_DEBOUNCE;
                            row_hot <= rs;
                            row_idx <= row_index(rs);
                        end else if (col_idx == COL_LAST) begin
                            // No clean hit on any column (none or ghost pattern).
                            state <= S_IDLE;
                            Col   <= '1;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                            Col     <= col_onehot(col_idx + 1'b1);
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end

                S_DEBOUNCE: begin
                    if (rs == row_hot) begin
                        if (cnt == DEB_LAST) begin
                            state <= S_PRESSED;
                            cnt   <= '0;
                            Valid <= 1'b1;
                            Held  <= 1'b1;
                            Code  <= CW'(int'(row_idx) * COLS + int'(col_idx));
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else begin
                        // Any disagreement aborts the press silently.
                        state <= S_IDLE;
                        Col   <= '1;
                        cnt   <= '0;
                    end
                end

                S_PRESSED: begin
                    // Only the latched row matters; other rows are ignored.
                    if ((rs & row_hot) == '0) begin
                        if (cnt == DEB_LAST) begin
                            state <= S_IDLE;
                            Held  <= 1'b0;
                            Col   <= '1;
                            cnt   <= '0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    Col   <= '1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
